// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 instruction prefetch unit.
package lc3_pkg;

    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/lc3_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head is the oldest entry, valid when count != 0.
module lc3_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/lc3_prefetch_queue.sv
// Instruction prefetch unit: sequential imem fetch FSM, PC register, redirect/flush,
// and a small queue of {instr, pc, npc} entries feeding decode.
module lc3_prefetch_queue
    import lc3_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_fetch,
    input  logic                       br_taken,
    input  logic [ADDR_W-1:0]          taddr,
    input  logic [DATA_W-1:0]          Instr_dout,
    input  logic                       complete_instr,
    output logic                       instrmem_rd,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]          out_npc,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int ENTRY_W = DATA_W + 2*ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] npc;
    } entry_t;

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_addr;
    logic              push;
    logic              pop;
    entry_t            push_entry;
    entry_t            head;
    logic [CNT_W-1:0]  count;

    assign next_addr  = imem_addr + ADDR_W'(1);
    // A redirect in the completion cycle kills the response and beats any pop.
    assign push       = (state == REQ) && complete_instr && !br_taken;
    assign pop        = out_valid && out_ready && !br_taken;
    assign push_entry = '{instr: Instr_dout, pc: imem_addr, npc: next_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instrmem_rd <= 1'b0;
            imem_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_fetch && (count < CNT_W'(DEPTH)) && !br_taken) begin
                        instrmem_rd <= 1'b1;
                        imem_addr   <= pc;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (complete_instr) begin
                        instrmem_rd <= 1'b0;
                        pc          <= next_addr;
                        state       <= IDLE;
                    end else if (br_taken) begin
                        // Memory cannot abort, so wait out the stale response.
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (complete_instr) begin
                        instrmem_rd <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (br_taken) pc <= taddr;
        end
    end

    lc3_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (br_taken),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    assign occupancy = count;
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_npc   = out_valid ? head.npc   : '0;

endmodule

// File: tb/tb_lc3_prefetch_queue.sv
// Directed bench for lc3_prefetch_queue with a fixed-latency imem responder (data = addr ^ 5A5A).
module tb_lc3_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_fetch = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] taddr = '0;
    logic [15:0] Instr_dout;
    logic        complete_instr;
    logic        instrmem_rd;
    logic [15:0] imem_addr;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_npc;
    logic [2:0]  occupancy;

    int          tests = 0;
    int          fails = 0;
    int          mem_lat = 2;
    int          cnt = 0;
    logic        prev_rd = 1'b0;
    logic [15:0] req_log [$];

    lc3_prefetch_queue #(
        .DATA_W (16), .ADDR_W (16), .DEPTH (4), .RESET_PC (16'h3000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_fetch   (enable_fetch),
        .br_taken       (br_taken),
        .taddr          (taddr),
        .Instr_dout     (Instr_dout),
        .complete_instr (complete_instr),
        .instrmem_rd    (instrmem_rd),
        .imem_addr      (imem_addr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_npc        (out_npc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    // imem model: completes mem_lat cycles after the request rises, logs each new request.
    initial begin
        complete_instr = 1'b0;
        Instr_dout     = '0;
        forever begin
            @(posedge clk); #1;
            complete_instr = 1'b0;
            if (instrmem_rd === 1'b1 && !prev_rd) req_log.push_back(imem_addr);
            prev_rd = (instrmem_rd === 1'b1);
            if (instrmem_rd === 1'b1) begin
                cnt++;
                if (cnt == mem_lat) begin
                    complete_instr = 1'b1;
                    Instr_dout     = imem_addr ^ 16'h5A5A;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; br_taken = 1'b0; out_ready = 1'b0; enable_fetch = 1'b0;
        tick(); tick();
        rst = 1'b0;
        req_log.delete();
    endtask

    // Stops in the first cycle a request to addr is outstanding.
    task automatic wait_issue(input logic [15:0] addr, input string name);
        bit hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            tick();
            if (instrmem_rd === 1'b1 && cnt == 1 && imem_addr === addr) hit = 1;
        end
        tests++;
        if (!hit) begin fails++; $display("FAIL %s: request to %h never issued", name, addr); end
    endtask

    task automatic wait_reqs(input int n, input string name);
        for (int k = 0; k < 100 && req_log.size() < n; k++) tick();
        tests++;
        if (req_log.size() < n) begin
            fails++; $display("FAIL %s: got %0d requests, expected %0d", name, req_log.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable_fetch = 1'b1;
        tick(); tick();
        tests++; if (instrmem_rd !== 1'b0) begin fails++; $display("FAIL reset_rd: got %b expected 0", instrmem_rd); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        tests++; if ({out_instr, out_pc, out_npc} !== 48'h0) begin
            fails++; $display("FAIL reset_head: got %h %h %h expected zeros", out_instr, out_pc, out_npc);
        end
        rst = 1'b0; enable_fetch = 1'b0;
    endtask

    task automatic test_sequential_fill();
        do_reset();
        enable_fetch = 1'b1;
        wait_reqs(3, "seq_reqs");
        if (req_log.size() >= 3) begin
            tests++; if (req_log[0] !== 16'h3000 || req_log[1] !== 16'h3001 || req_log[2] !== 16'h3002) begin
                fails++; $display("FAIL seq_order: got %h %h %h expected 3000 3001 3002", req_log[0], req_log[1], req_log[2]);
            end
        end
        tests++; if (out_pc !== 16'h3000 || out_npc !== 16'h3001 || out_instr !== 16'h6A5A) begin
            fails++; $display("FAIL seq_head: got %h/%h/%h expected 3000/3001/6A5A", out_pc, out_npc, out_instr);
        end
        for (int k = 0; k < 60 && occupancy !== 3'd4; k++) tick();
        tick(); tick(); tick();
        tests++; if (occupancy !== 3'd4) begin fails++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
        tests++; if (instrmem_rd !== 1'b0) begin fails++; $display("FAIL fill_rd: got %b expected 0", instrmem_rd); end
        tests++; if (req_log.size() != 4) begin fails++; $display("FAIL fill_reqs: got %0d expected 4", req_log.size()); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++; if (occupancy !== 3'd3 || out_pc !== 16'h3001) begin
            fails++; $display("FAIL pop_one: got occ %0d pc %h expected 3 3001", occupancy, out_pc);
        end
        wait_reqs(5, "refill_req");
        if (req_log.size() >= 5) begin
            tests++; if (req_log[4] !== 16'h3004) begin fails++; $display("FAIL refill_addr: got %h expected 3004", req_log[4]); end
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        enable_fetch = 1'b1;
        wait_issue(16'h3002, "redir_wait");
        tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL redir_pre_occ: got %0d expected 2", occupancy); end
        br_taken = 1'b1; taddr = 16'h4000;
        tick();
        br_taken = 1'b0;
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL redir_flush: got occ %0d valid %b expected 0 0", occupancy, out_valid);
        end
        tests++; if (instrmem_rd !== 1'b1) begin fails++; $display("FAIL redir_hold_rd: got %b expected 1", instrmem_rd); end
        tick();
        tests++; if (occupancy !== 3'd0 || instrmem_rd !== 1'b0) begin
            fails++; $display("FAIL redir_drop: got occ %0d rd %b expected 0 0", occupancy, instrmem_rd);
        end
        wait_reqs(4, "redir_req");
        if (req_log.size() >= 4) begin
            tests++; if (req_log[3] !== 16'h4000) begin fails++; $display("FAIL redir_addr: got %h expected 4000", req_log[3]); end
        end
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) tick();
        tests++; if (out_pc !== 16'h4000 || out_npc !== 16'h4001 || out_instr !== 16'h1A5A) begin
            fails++; $display("FAIL redir_head: got %h/%h/%h expected 4000/4001/1A5A", out_pc, out_npc, out_instr);
        end
    endtask

    task automatic test_br_with_complete();
        do_reset();
        enable_fetch = 1'b1;
        wait_issue(16'h3000, "brc_wait");
        tick();
        br_taken = 1'b1; taddr = 16'h5000;
        tick();
        br_taken = 1'b0;
        tests++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || instrmem_rd !== 1'b0) begin
            fails++; $display("FAIL brc_nopush: got occ %0d valid %b rd %b expected 0 0 0", occupancy, out_valid, instrmem_rd);
        end
        wait_reqs(2, "brc_req");
        if (req_log.size() >= 2) begin
            tests++; if (req_log[1] !== 16'h5000) begin fails++; $display("FAIL brc_addr: got %h expected 5000", req_log[1]); end
        end
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) tick();
        tests++; if (out_pc !== 16'h5000) begin fails++; $display("FAIL brc_head: got %h expected 5000", out_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        br_taken = 1'b1; taddr = 16'hFFFF;
        tick();
        br_taken = 1'b0; enable_fetch = 1'b1;
        wait_reqs(2, "wrap_reqs");
        if (req_log.size() >= 2) begin
            tests++; if (req_log[0] !== 16'hFFFF || req_log[1] !== 16'h0000) begin
                fails++; $display("FAIL wrap_addr: got %h %h expected FFFF 0000", req_log[0], req_log[1]);
            end
        end
        tests++; if (out_pc !== 16'hFFFF || out_npc !== 16'h0000 || out_instr !== 16'hA5A5) begin
            fails++; $display("FAIL wrap_head: got %h/%h/%h expected FFFF/0000/A5A5", out_pc, out_npc, out_instr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable_fetch = 1'b1;
        wait_issue(16'h3001, "rstmid_wait");
        tick();
        rst = 1'b1;
        tick();
        tests++; if (instrmem_rd !== 1'b0 || imem_addr !== 16'h0000) begin
            fails++; $display("FAIL rstmid_req: got rd %b addr %h expected 0 0000", instrmem_rd, imem_addr);
        end
        tests++; if (out_valid !== 1'b0 || occupancy !== 3'd0 || {out_instr, out_pc, out_npc} !== 48'h0) begin
            fails++; $display("FAIL rstmid_out: got valid %b occ %0d pc %h expected 0 0 0000", out_valid, occupancy, out_pc);
        end
        rst = 1'b0;
        req_log.delete();
        wait_reqs(1, "rstmid_req");
        if (req_log.size() >= 1) begin
            tests++; if (req_log[0] !== 16'h3000) begin fails++; $display("FAIL rstmid_addr: got %h expected 3000", req_log[0]); end
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        enable_fetch = 1'b1;
        wait_issue(16'h3002, "pp_wait");
        tests++; if (occupancy !== 3'd2) begin fails++; $display("FAIL pp_pre_occ: got %0d expected 2", occupancy); end
        tick();
        out_ready = 1'b1;
        tick();
        tests++; if (occupancy !== 3'd2 || out_pc !== 16'h3001 || out_instr !== 16'h6A5B) begin
            fails++; $display("FAIL pp_same: got occ %0d pc %h instr %h expected 2 3001 6A5B", occupancy, out_pc, out_instr);
        end
        enable_fetch = 1'b0;
        tick();
        out_ready = 1'b0;
        tests++; if (occupancy !== 3'd1 || out_pc !== 16'h3002 || out_npc !== 16'h3003) begin
            fails++; $display("FAIL pp_order: got occ %0d pc %h npc %h expected 1 3002 3003", occupancy, out_pc, out_npc);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_fill();
        test_redirect_inflight();
        test_br_with_complete();
        test_wrap();
        test_reset_mid();
        test_push_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
